// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: one-hot T1..T6 ring counter decoded with the IR opcode
// into the control word for the PC, MAR, RAM, IR, A, B, output register and ALU.
module sap1_controller #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       run_i,
    input  logic [3:0] ir_opcode_i,
    output logic       cp_o,
    output logic       ep_o,
    output logic       lm_o,
    output logic       ce_o,
    output logic       li_o,
    output logic       ei_o,
    output logic       la_o,
    output logic       ea_o,
    output logic       su_o,
    output logic       eu_o,
    output logic       lb_o,
    output logic       lo_o,
    output logic       halted_o,
    output logic [5:0] tstate_o
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_t;

    tstate_t tstate_reg, tstate_next;
    logic    halted_reg, halted_next;
    logic    tstate_legal;

    assign tstate_legal = $onehot(tstate_reg);
    assign tstate_o     = tstate_reg;
    assign halted_o     = halted_reg;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            tstate_reg <= T1;
            halted_reg <= 1'b0;
        end else begin
            tstate_reg <= tstate_next;
            halted_reg <= halted_next;
        end
    end

    // A corrupted ring recovers to T1 regardless of run/halt so it never wedges.
    always_comb begin
        tstate_next = tstate_reg;
        halted_next = halted_reg;
        if (!tstate_legal) begin
            tstate_next = T1;
        end else if (run_i && !halted_reg) begin
            if (tstate_reg == T4 && ir_opcode_i == OP_HLT) begin
                halted_next = 1'b1;
            end else begin
                tstate_next = tstate_t'({tstate_reg[4:0], tstate_reg[5]});
            end
        end
    end

    // Control word decode; everything is quiet in reset, pause and halt.
    always_comb begin
        cp_o = 1'b0;
        ep_o = 1'b0;
        lm_o = 1'b0;
        ce_o = 1'b0;
        li_o = 1'b0;
        ei_o = 1'b0;
        la_o = 1'b0;
        ea_o = 1'b0;
        su_o = 1'b0;
        eu_o = 1'b0;
        lb_o = 1'b0;
        lo_o = 1'b0;
        if (rstn_i && run_i && !halted_reg) begin
            case (tstate_reg)
                T1: begin
                    ep_o = 1'b1;
                    lm_o = 1'b1;
                end
                T2: cp_o = 1'b1;
                T3: begin
                    ce_o = 1'b1;
                    li_o = 1'b1;
                end
                T4: begin
                    if (ir_opcode_i == OP_LDA || ir_opcode_i == OP_ADD || ir_opcode_i == OP_SUB) begin
                        ei_o = 1'b1;
                        lm_o = 1'b1;
                    end else if (ir_opcode_i == OP_OUT) begin
                        ea_o = 1'b1;
                        lo_o = 1'b1;
                    end
                end
                T5: begin
                    if (ir_opcode_i == OP_LDA) begin
                        ce_o = 1'b1;
                        la_o = 1'b1;
                    end else if (ir_opcode_i == OP_ADD || ir_opcode_i == OP_SUB) begin
                        ce_o = 1'b1;
                        lb_o = 1'b1;
                        su_o = (ir_opcode_i == OP_SUB);
                    end
                end
                T6: begin
                    // su stays up from T5 so the registered ALU result is the difference.
                    if (ir_opcode_i == OP_ADD || ir_opcode_i == OP_SUB) begin
                        eu_o = 1'b1;
                        la_o = 1'b1;
                        su_o = (ir_opcode_i == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sap1_controller.sv
// Scoreboard bench for sap1_controller: the driver queues hand-computed per-cycle
// expectations, and a negedge monitor pops and compares them.
module tb_sap1_controller;

    logic       clk;
    logic       rstn;
    logic       run;
    logic [3:0] op;
    logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, halted;
    logic [5:0] tstate;

    // Control word packing: {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
    localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
    localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
    localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;
    localparam logic [11:0] NONE = 12'h000;

    typedef struct {
        logic [5:0]  t;
        logic        h;
        logic [11:0] c;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    sap1_controller dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .run_i       (run),
        .ir_opcode_i (op),
        .cp_o        (cp),
        .ep_o        (ep),
        .lm_o        (lm),
        .ce_o        (ce),
        .li_o        (li),
        .ei_o        (ei),
        .la_o        (la),
        .ea_o        (ea),
        .su_o        (su),
        .eu_o        (eu),
        .lb_o        (lb),
        .lo_o        (lo),
        .halted_o    (halted),
        .tstate_o    (tstate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one transaction per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [11:0] ctrl;
            e = sb.pop_front();
            ctrl = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};
            tests_run += 3;
            if (tstate !== e.t) begin
                tests_failed++;
                $display("FAIL %s tstate: got %h expected %h", e.name, tstate, e.t);
            end
            if (halted !== e.h) begin
                tests_failed++;
                $display("FAIL %s halted: got %b expected %b", e.name, halted, e.h);
            end
            if (ctrl !== e.c) begin
                tests_failed++;
                $display("FAIL %s ctrl: got %h expected %h", e.name, ctrl, e.c);
            end
            $display("[TB] %-10s rstn=%b run=%b op=%h t=%h h=%b ctrl=%h", e.name, rstn, run, op, tstate, halted, ctrl);
        end
    end

    task automatic step(input logic r, input logic rn, input logic [3:0] o,
                        input logic [5:0] t, input logic h, input logic [11:0] c,
                        input string nm);
        exp_t e;
        rstn = r;
        run  = rn;
        op   = o;
        e.t = t; e.h = h; e.c = c; e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Fetch cycles shared by every instruction.
    task automatic fetch(input logic [3:0] o, input string nm);
        step(1, 1, o, 6'h01, 0, EP | LM, nm);
        step(1, 1, o, 6'h02, 0, CP,      nm);
        step(1, 1, o, 6'h04, 0, CE | LI, nm);
    endtask

    initial begin
        rstn = 1'b0;
        run  = 1'b1;
        op   = 4'h0;
        @(posedge clk);
        #1;

        step(0, 1, 4'h0, 6'h01, 0, NONE, "reset");
        step(0, 1, 4'h0, 6'h01, 0, NONE, "reset");

        fetch(4'h0, "lda");
        step(1, 1, 4'h0, 6'h08, 0, EI | LM, "lda");
        step(1, 1, 4'h0, 6'h10, 0, CE | LA, "lda");
        step(1, 1, 4'h0, 6'h20, 0, NONE,    "lda");

        fetch(4'h1, "add");
        step(1, 1, 4'h1, 6'h08, 0, EI | LM,      "add");
        step(1, 1, 4'h1, 6'h10, 0, CE | LB,      "add");
        step(1, 1, 4'h1, 6'h20, 0, EU | LA,      "add");

        fetch(4'h2, "sub");
        step(1, 1, 4'h2, 6'h08, 0, EI | LM,      "sub");
        step(1, 1, 4'h2, 6'h10, 0, CE | LB | SU, "sub");
        step(1, 1, 4'h2, 6'h20, 0, EU | LA | SU, "sub");

        fetch(4'hE, "out");
        step(1, 1, 4'hE, 6'h08, 0, EA | LO, "out");
        step(1, 1, 4'hE, 6'h10, 0, NONE,    "out");
        step(1, 1, 4'hE, 6'h20, 0, NONE,    "out");

        fetch(4'h7, "nop");
        step(1, 1, 4'h7, 6'h08, 0, NONE, "nop");
        step(1, 1, 4'h7, 6'h10, 0, NONE, "nop");
        step(1, 1, 4'h7, 6'h20, 0, NONE, "nop");

        // Pause in T3
        step(1, 1, 4'h0, 6'h01, 0, EP | LM, "pause");
        step(1, 1, 4'h0, 6'h02, 0, CP,      "pause");
        for (int i = 0; i < 5; i++)
            step(1, 0, 4'h0, 6'h04, 0, NONE, "pause");
        step(1, 1, 4'h0, 6'h04, 0, CE | LI, "resume");
        step(1, 1, 4'h0, 6'h08, 0, EI | LM, "resume");
        step(1, 1, 4'h0, 6'h10, 0, CE | LA, "resume");
        step(1, 1, 4'h0, 6'h20, 0, NONE,    "resume");

        // Reset aborts SUB in T5
        fetch(4'h2, "abort");
        step(1, 1, 4'h2, 6'h08, 0, EI | LM, "abort");
        step(0, 1, 4'h2, 6'h10, 0, NONE,    "abort");
        step(1, 1, 4'h2, 6'h01, 0, EP | LM, "abort");
        step(1, 1, 4'h2, 6'h02, 0, CP,      "abort");

        // Complete that SUB, then halt
        step(1, 1, 4'h2, 6'h04, 0, CE | LI,      "sub2");
        step(1, 1, 4'h2, 6'h08, 0, EI | LM,      "sub2");
        step(1, 1, 4'h2, 6'h10, 0, CE | LB | SU, "sub2");
        step(1, 1, 4'h2, 6'h20, 0, EU | LA | SU, "sub2");

        fetch(4'hF, "hlt");
        step(1, 1, 4'hF, 6'h08, 0, NONE, "hlt");
        for (int i = 0; i < 20; i++)
            step(1, logic'(i % 2), (i % 3 == 0) ? 4'h0 : 4'hF, 6'h08, 1, NONE, "halted");
        step(0, 1, 4'h0, 6'h08, 1, NONE,    "hltreset");
        step(1, 1, 4'h0, 6'h01, 0, EP | LM, "restart");
        step(1, 1, 4'h0, 6'h02, 0, CP,      "restart");

        for (int i = 0; i < 10 && sb.size() != 0; i++)
            @(negedge clk);
        #1;
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
